// File: rtl/cpu_pkg.sv
// Shared widths and the MEM/WB pipeline register layout for the 8-bit pipeline.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned REG_W  = 3;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] ldata;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
    logic              regwr;
    logic              m2r;
  } memwb_t;

endpackage

// File: rtl/data_mem_array.sv
// Byte-wide data memory: synchronous write, combinational read, contents never reset.
module data_mem_array
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read sees the pre-edge contents, giving read-before-write on a same-address store.
  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_stage.sv
// MEM stage: data memory access plus the MEM/WB register with stall/flush handling
// and a sticky flag for simultaneous read+write requests.
module data_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned REG_W  = cpu_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exmem_valid,
  input  logic              exmem_mem_rd,
  input  logic              exmem_mem_wr,
  input  logic [ADDR_W-1:0] exmem_addr,
  input  logic [DATA_W-1:0] exmem_alu,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              exmem_regwr,
  input  logic              exmem_m2r,
  input  logic              stall,
  input  logic              flush,
  output logic              memwb_valid,
  output logic [DATA_W-1:0] memwb_ldata,
  output logic [DATA_W-1:0] memwb_alu,
  output logic [REG_W-1:0]  memwb_rd,
  output logic              memwb_regwr,
  output logic              memwb_m2r,
  output logic              rw_conflict
);

  logic              w_live;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  memwb_t            w_next;
  memwb_t            r_memwb;
  logic              r_conflict;

  assign w_live = exmem_valid & ~flush & ~stall;
  assign w_we   = w_live & exmem_mem_wr;

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (exmem_addr),
    .i_wdata (store_data),
    .o_rdata (w_rdata)
  );

  // Bubble whenever the slot is dead (flush or invalid); stall is handled at the register.
  always_comb begin
    w_next = '0;
    if (exmem_valid && !flush) begin
      w_next.valid = 1'b1;
      w_next.ldata = exmem_mem_rd ? w_rdata : '0;
      w_next.alu   = exmem_alu;
      w_next.rd    = exmem_rd;
      w_next.regwr = exmem_regwr;
      w_next.m2r   = exmem_m2r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memwb    <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (!stall) begin
        r_memwb <= w_next;
      end
      if (w_live && exmem_mem_rd && exmem_mem_wr) begin
        r_conflict <= 1'b1;
      end
    end
  end

  assign memwb_valid = r_memwb.valid;
  assign memwb_ldata = r_memwb.ldata;
  assign memwb_alu   = r_memwb.alu;
  assign memwb_rd    = r_memwb.rd;
  assign memwb_regwr = r_memwb.regwr;
  assign memwb_m2r   = r_memwb.m2r;
  assign rw_conflict = r_conflict;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: stores, loads, stall/flush priority, conflict flag, reset.
module tb_data_mem_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       exmem_valid, exmem_mem_rd, exmem_mem_wr;
  logic [7:0] exmem_addr, exmem_alu, store_data;
  logic [2:0] exmem_rd;
  logic       exmem_regwr, exmem_m2r, stall, flush;
  logic       memwb_valid;
  logic [7:0] memwb_ldata, memwb_alu;
  logic [2:0] memwb_rd;
  logic       memwb_regwr, memwb_m2r, rw_conflict;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  data_mem_stage #(.DATA_W(8), .ADDR_W(8), .REG_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .exmem_valid  (exmem_valid),
    .exmem_mem_rd (exmem_mem_rd),
    .exmem_mem_wr (exmem_mem_wr),
    .exmem_addr   (exmem_addr),
    .exmem_alu    (exmem_alu),
    .store_data   (store_data),
    .exmem_rd     (exmem_rd),
    .exmem_regwr  (exmem_regwr),
    .exmem_m2r    (exmem_m2r),
    .stall        (stall),
    .flush        (flush),
    .memwb_valid  (memwb_valid),
    .memwb_ldata  (memwb_ldata),
    .memwb_alu    (memwb_alu),
    .memwb_rd     (memwb_rd),
    .memwb_regwr  (memwb_regwr),
    .memwb_m2r    (memwb_m2r),
    .rw_conflict  (rw_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] alu, input logic [7:0] sd, input logic [2:0] dst,
                       input logic rw, input logic m2r);
    exmem_valid  = v;
    exmem_mem_rd = rd;
    exmem_mem_wr = wr;
    exmem_addr   = a;
    exmem_alu    = alu;
    store_data   = sd;
    exmem_rd     = dst;
    exmem_regwr  = rw;
    exmem_m2r    = m2r;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    drive(1, 0, 1, a, 8'h00, d, 3'd0, 0, 0);
    step();
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] alu, input logic [2:0] dst);
    drive(1, 1, 0, a, alu, 8'h00, dst, 1, 1);
    step();
  endtask

  // Packs all MEM/WB outputs plus the flag: {valid,ldata,alu,rd,regwr,m2r,conflict}
  function automatic logic [31:0] outs();
    return {9'd0, memwb_valid, memwb_ldata, memwb_alu, memwb_rd, memwb_regwr, memwb_m2r, rw_conflict};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
    step();
    step();
    check("reset_state", outs(), 32'd0);
    reset = 1'b0;

    store(8'h20, 8'h5A);
    store(8'h05, 8'h99);
    store(8'h30, 8'h11);

    load(8'h20, 8'h44, 3'd3);
    check("preload_20", memwb_ldata, 8'h5A);
    check("load_alu", memwb_alu, 8'h44);
    #3 reset = 1'b1;
    #1 check("async_reset", outs(), 32'd0);
    reset = 1'b0;

    store(8'h10, 8'hA5);
    check("store_bubble_regwr", memwb_regwr, 1'b0);
    load(8'h10, 8'h12, 3'd2);
    check("ld10_ldata", memwb_ldata, 8'hA5);
    check("ld10_ctl", {memwb_valid, memwb_m2r, memwb_regwr, memwb_rd}, {3'b111, 3'd2});
    check("ld10_alu", memwb_alu, 8'h12);

    stall = 1'b1;
    drive(1, 0, 1, 8'h20, 8'h77, 8'h3C, 3'd5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", {memwb_valid, memwb_ldata, memwb_alu, memwb_rd, memwb_m2r},
            {1'b1, 8'hA5, 8'h12, 3'd2, 1'b1});
    end
    stall = 1'b0;
    load(8'h20, 8'h00, 3'd1);
    check("no_store_in_stall", memwb_ldata, 8'h5A);

    flush = 1'b1;
    drive(1, 0, 1, 8'h05, 8'h66, 8'h77, 3'd4, 1, 1);
    step();
    check("flush_bubble", outs(), 32'd0);
    flush = 1'b0;
    load(8'h05, 8'h00, 3'd1);
    check("no_store_in_flush", memwb_ldata, 8'h99);

    check("conflict_clear", rw_conflict, 1'b0);
    drive(1, 1, 1, 8'h30, 8'h00, 8'h22, 3'd6, 1, 1);
    step();
    check("rbw_old_data", memwb_ldata, 8'h11);
    check("conflict_set", rw_conflict, 1'b1);
    load(8'h30, 8'h00, 3'd6);
    check("rbw_new_data", memwb_ldata, 8'h22);
    drive(1, 0, 0, 8'h30, 8'h55, 8'h00, 3'd7, 1, 0);
    step();
    check("no_rd_ldata_zero", {memwb_ldata, memwb_alu, memwb_m2r}, {8'h00, 8'h55, 1'b0});
    check("conflict_sticky", rw_conflict, 1'b1);

    store(8'hFF, 8'hC3);
    load(8'hFF, 8'hAB, 3'd5);
    check("addr_ff", memwb_ldata, 8'hC3);
    stall = 1'b1;
    flush = 1'b1;
    drive(1, 1, 1, 8'hFF, 8'h01, 8'h00, 3'd1, 1, 0);
    step();
    check("stall_over_flush", {memwb_valid, memwb_ldata, memwb_alu, memwb_rd},
          {1'b1, 8'hC3, 8'hAB, 3'd5});
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 0, 1, 8'hFF, 8'h01, 8'h11, 3'd1, 1, 1);
    step();
    check("invalid_bubble", {memwb_valid, memwb_regwr, memwb_m2r}, 3'b000);
    load(8'hFF, 8'h00, 3'd2);
    check("ff_untouched", memwb_ldata, 8'hC3);

    stall = 1'b1;
    drive(1, 1, 0, 8'hFF, 8'h00, 8'h00, 3'd2, 1, 1);
    step();
    #2 reset = 1'b1;
    #1 check("reset_mid_stall", outs(), 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
    step();
    check("resume_bubble", outs(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
